param_fifo_sync: RTL and testbench

Parametrised synchronous FIFO. It is the next-generation buffer for the per-channel data paths, with arbitrary depth of 2**ADDR_BITS.
- Uses an extended-pointer full/empty scheme.
- Exposes an occupancy count and programmable almost-full/almost-empty thresholds.
- Reports overflow/underflow errors as registered pulses.
- Sits between a packet producer and a downstream arbiter/demux, which use almost_full for flow control.

---
 rtl/param_fifo_pkg.sv | 17 +
 rtl/fifo_dp_ram.sv | 55 +++++
 rtl/param_fifo_sync.sv | 100 ++++++++++
 tb/tb_param_fifo_sync.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// rtl/param_fifo_pkg.sv - shared depth helper and pointer/count types for param_fifo_sync
package param_fifo_pkg;

    localparam int DEFAULT_ADDR_BITS = 3;

    // Number of words addressable by an address of the given width
    function automatic int fifo_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    // Extended pointer: low bits address the RAM, MSB is the wrap phase
    typedef logic [DEFAULT_ADDR_BITS:0] fifo_ptr_t;

    // Occupancy 0..DEPTH needs one bit more than the RAM address
    typedef logic [DEFAULT_ADDR_BITS:0] fifo_cnt_t;

endpackage

// File: rtl/fifo_dp_ram.sv
// rtl/fifo_dp_ram.sv - simple dual-port RAM, registered read (async read with PARAM_FIFO_FWFT_EN)
module fifo_dp_ram #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);
    import param_fifo_pkg::*;

    localparam int DEPTH = fifo_depth(ADDR_BITS);

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Storage array is never cleared; only written words are ever read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef PARAM_FIFO_FWFT_EN
    // Head word is shown directly; the read port needs no clock or enable
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = ^{reset, rd_en};
    assign rd_data = mem[rd_addr];
`else
    logic [DATA_BITS-1:0] rd_data_q;
    logic [DATA_BITS-1:0] rd_data_d;

    // Output register loads on a pop and otherwise holds the last popped word
    always_comb begin
        rd_data_d = rd_data_q;
        if (!reset) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Read data register
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/param_fifo_sync.sv
// rtl/param_fifo_sync.sv - synchronous FIFO with extended pointers, thresholds, error pulse; PARAM_FIFO_FWFT_EN selects fall-through read
module param_fifo_sync #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   count,
    input  logic [ADDR_BITS:0]   high_limit,
    input  logic [ADDR_BITS:0]   low_limit,
    output logic                 error_out
);
    import param_fifo_pkg::*;

    localparam int PTR_BITS = ADDR_BITS + 1;
    localparam logic [PTR_BITS-1:0] DEPTH_C = PTR_BITS'(fifo_depth(ADDR_BITS));
    localparam logic [PTR_BITS-1:0] PTR_ONE = PTR_BITS'(1);

    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic                error_q, error_d;
    logic                wr_acc, rd_acc;

    // Occupancy and flags come straight from the pointer difference
    always_comb begin
        count        = wr_ptr_q - rd_ptr_q;
        full         = (count == DEPTH_C);
        empty        = (count == '0);
        almost_full  = (count >= high_limit);
        almost_empty = (count <= low_limit);
        wr_acc       = wr_en & ~full;
        rd_acc       = rd_en & ~empty;
    end

    // Pointer advance and error detection; reset wins over any request
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        error_d  = 1'b0;
        if (!reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
            error_d = (wr_en & full) | (rd_en & empty);
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        error_q  <= error_d;
    end

    assign error_out = error_q;

    fifo_dp_ram #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc & reset),
        .wr_addr (wr_ptr_q[ADDR_BITS-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc & reset),
        .rd_addr (rd_ptr_q[ADDR_BITS-1:0]),
        .rd_data (rd_data)
    );

`ifdef PARAM_FIFO_FWFT_EN
    assign rd_valid = ~empty;
`else
    logic rd_valid_q, rd_valid_d;

    // rd_valid marks the single cycle after a pop
    always_comb begin
        rd_valid_d = reset & rd_acc;
    end

    // rd_valid register
    always_ff @(posedge clk) begin
        rd_valid_q <= rd_valid_d;
    end

    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_param_fifo_sync.sv
// tb/tb_param_fifo_sync.sv - self-checking bench for param_fifo_sync against a queue model
module tb_param_fifo_sync;

    localparam int DB    = 10;
    localparam int AB    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [DB-1:0] wr_data;
    logic          rd_en;
    logic [DB-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AB:0]   count;
    logic [AB:0]   high_limit;
    logic [AB:0]   low_limit;
    logic          error_out;

    param_fifo_sync #(.DATA_BITS(DB), .ADDR_BITS(AB)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .high_limit   (high_limit),
        .low_limit    (low_limit),
        .error_out    (error_out)
    );

    always #5 clk = ~clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [DB-1:0] model_q[$];
    logic [DB-1:0] exp_rd_data = '0;
    logic          exp_rd_valid = 1'b0;
    logic          exp_err = 1'b0;
    bit            saw_3ff = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ":count"}, 32'(count), 32'(sz));
        chk({tag, ":full"}, 32'(full), 32'(sz == DEPTH));
        chk({tag, ":empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, ":almost_full"}, 32'(almost_full), 32'(sz >= int'(high_limit)));
        chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(sz <= int'(low_limit)));
        chk({tag, ":error_out"}, 32'(error_out), 32'(exp_err));
`ifdef PARAM_FIFO_FWFT_EN
        chk({tag, ":rd_valid"}, 32'(rd_valid), 32'(sz != 0));
        if (sz != 0) chk({tag, ":rd_data"}, 32'(rd_data), 32'(model_q[0]));
`else
        chk({tag, ":rd_valid"}, 32'(rd_valid), 32'(exp_rd_valid));
        chk({tag, ":rd_data"}, 32'(rd_data), 32'(exp_rd_data));
`endif
    endtask

    // One clock: drive inputs, advance the model on pre-edge state, check at negedge
    task automatic step(input string tag, input logic rst_n, input logic we,
                        input logic [DB-1:0] wd, input logic re);
        int  sz;
        bit  is_full, is_empty;
        reset   = rst_n;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        sz       = model_q.size();
        is_full  = (sz == DEPTH);
        is_empty = (sz == 0);
        if (!rst_n) begin
            model_q.delete();
            exp_rd_data  = '0;
            exp_rd_valid = 1'b0;
            exp_err      = 1'b0;
        end else begin
            exp_err      = (we && is_full) || (re && is_empty);
            exp_rd_valid = 1'b0;
            if (re && !is_empty) begin
                exp_rd_data  = model_q.pop_front();
                exp_rd_valid = 1'b1;
                if (exp_rd_data == 10'h3FF && saw_3ff == 1'b0) saw_3ff = 1'b0;
            end
            if (we && !is_full) model_q.push_back(wd);
        end
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        reset      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        rd_en      = 1'b0;
        high_limit = 4'd6;
        low_limit  = 4'd1;

        // Reset then idle
        step("reset", 1'b0, 1'b0, '0, 1'b0);
        step("reset2", 1'b0, 1'b0, '0, 1'b0);
        step("idle", 1'b1, 1'b0, '0, 1'b0);

        // Fill 0x001..0x008
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b1, DB'(i), 1'b0);

        // Overflow attempt: dropped, one-cycle error pulse
        step("ovf", 1'b1, 1'b1, 10'h3FF, 1'b0);
        step("ovf_clear", 1'b1, 1'b0, '0, 1'b0);

        // Drain 8 words in order
        for (int i = 1; i <= DEPTH; i++) begin
            step("drain_pop", 1'b1, 1'b0, '0, 1'b1);
            chk("drain_order", 32'(rd_data), 32'(i));
        end
        step("drain_idle", 1'b1, 1'b0, '0, 1'b0);

        // Underflow
        step("udf", 1'b1, 1'b0, '0, 1'b1);
        step("udf_clear", 1'b1, 1'b0, '0, 1'b0);

        // Simultaneous read/write at count 4 across the pointer wrap
        for (int i = 0; i < 4; i++) step("pre_wrap", 1'b1, 1'b1, DB'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) step("wrap", 1'b1, 1'b1, DB'($urandom), 1'b1);

        // Full with both requests: only the read is accepted
        step("to_full", 1'b1, 1'b1, DB'($urandom), 1'b0);
        while (model_q.size() < DEPTH) step("to_full", 1'b1, 1'b1, DB'($urandom), 1'b0);
        step("full_rw", 1'b1, 1'b1, 10'h3FF, 1'b1);

        // Empty with both requests: only the write is accepted
        while (model_q.size() > 0) step("to_empty", 1'b1, 1'b0, '0, 1'b1);
        step("empty_rw", 1'b1, 1'b1, 10'h2AA, 1'b1);
        step("empty_rw_pop", 1'b1, 1'b0, '0, 1'b1);

        // Reset mid-operation at count 5, overriding wr_en/rd_en
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b1, DB'($urandom), 1'b0);
        step("mid_rst", 1'b0, 1'b1, 10'h123, 1'b1);
        step("post_rst_wr", 1'b1, 1'b1, 10'h155, 1'b0);
        step("post_rst_rd", 1'b1, 1'b0, '0, 1'b1);
        chk("first_after_rst", 32'(rd_data), 32'h155);

        // Random traffic with the nominal thresholds
        for (int i = 0; i < 300; i++)
            step("rand", 1'b1, 1'($urandom_range(0, 99) < 55), DB'($urandom),
                 1'($urandom_range(0, 99) < 45));

        // Out-of-range thresholds: almost_full never, almost_empty always
        high_limit = 4'd9;
        low_limit  = 4'd8;
        for (int i = 0; i < 150; i++)
            step("rand_lim", 1'b1, 1'($urandom_range(0, 99) < 60), DB'($urandom),
                 1'($urandom_range(0, 99) < 40));

        // Threshold zero: almost_full always, almost_empty only when empty
        high_limit = 4'd0;
        low_limit  = 4'd0;
        step("lim0_rst", 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 60; i++)
            step("rand_lim0", 1'b1, 1'($urandom_range(0, 1)), DB'($urandom),
                 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
